free_space_down_counter: RTL
============================

Name: free_space_down_counter

Overview:
- Sequential counterpart of the counters' ripple adder: tracks free parking spaces, decrementing on car entry and incrementing on car exit.
- All arithmetic uses one ripple-borrow subtractor chain. Increment is computed as a subtraction of all-ones, i.e. -1 in two's complement.
- Sits between the gate sensors and the display/gate-control logic.
- Provides synchronized sensor edge detection, full/empty flags and reject/error pulses.

Parameters:
- WIDTH, 4, bit width of the free-space count; CAPACITY must be < 2**WIDTH.
- CAPACITY, 10, number of spaces; the reset and reload value of free_count.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- enter_sensor  input  1  asynchronous level from the entry sensor; car present = 1.
- exit_sensor  input  1  asynchronous level from the exit sensor; car present = 1.
- reload  input  1  synchronous; forces free_count to CAPACITY.
- free_count  output  WIDTH  registered number of free spaces.
- lot_full  output  1  registered; 1 when free_count == 0.
- lot_empty  output  1  registered; 1 when free_count == CAPACITY.
- reject  output  1  registered one-cycle pulse: entry seen while full.
- exit_error  output  1  registered one-cycle pulse: exit seen while empty.

Behaviour:
- Reset (rst_n low, asynchronous, dominates everything):
  - free_count = CAPACITY, lot_full = 0, lot_empty = 1, reject = 0, exit_error = 0.
  - All synchronizer and edge registers = 0.
- Synchronization:
  - Each sensor passes through two flops (s1, s2), then a history flop s3.
  - Event pulse ev = s2 & ~s3, combinational and one cycle wide.
- Latency:
  - A sensor level first sampled high at edge N gives ev high between edges N+1 and N+2.
  - free_count and the flags update at edge N+2.
  - A level held high produces exactly one event; it must drop for at least 1 cycle to re-arm.
- Datapath:
  - next = free_count - operand, through a WIDTH-long full_subtractor chain.
  - Borrow-in of bit 0 = 0; final borrow-out is discarded, so the result is mod 2**WIDTH.
  - operand = 1 for an accepted entry; operand = all-ones for an accepted exit.
- Per-cycle priority, evaluated on the synchronized event pulses (ev_in, ev_out):
  1. reload = 1: free_count <- CAPACITY. Events in the same cycle are dropped with no reject/exit_error.
  2. ev_in and ev_out both high: no change and no pulses. The car swap is net zero, even when full or empty.
  3. ev_in only:
     - free_count != 0: decrement.
     - free_count == 0: hold and pulse reject for 1 cycle.
  4. ev_out only:
     - free_count != CAPACITY: increment.
     - free_count == CAPACITY: hold and pulse exit_error for 1 cycle.
  5. Otherwise: hold.
- Flags: lot_full and lot_empty are registered from the next-state value, so they change in the same cycle as free_count.
- Wrap-around never occurs; the guards in steps 3 and 4 keep free_count within 0..CAPACITY.
- Reset mid-event: a pending s1/s2 level is discarded. A sensor still high after reset releases counts once, after two sync cycles, as a new event.

Decomposition:
- Shared package/include: parameter defaults (WIDTH, CAPACITY) and the CAPACITY < 2**WIDTH check, reused by the display and gate controller.
- One sub-module, full_subtractor:
  - Ports: bit1, bit2, borrow_in, result, borrow_out.
  - Equations: result = a ^ b ^ bin; borrow_out = (~a & b) | (~(a ^ b) & bin).
  - Instantiated WIDTH times with a generate loop.
- Synchronizer and control stay inline.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle -> immediately free_count = 10, lot_empty = 1, lot_full = 0, pulses 0. Release reset, no stimulus -> values hold for 20 cycles.
- Single entry: enter_sensor high at edge N, held for 5 cycles -> free_count = 9 at edge N+2, exactly one decrement, lot_empty drops at the same edge.
- Fill and reject: 10 separated entry pulses -> free_count = 0 and lot_full = 1. An 11th entry -> free_count stays 0 and reject is high for exactly one cycle.
- Exit at empty: from reset, one exit pulse -> free_count stays 10 and exit_error pulses once. Then 3 entries and 1 exit -> free_count = 8.
- Simultaneous events: at free_count = 0, enter and exit rise on the same edge -> free_count stays 0 and no reject; repeat at 10 -> stays 10 and no exit_error.
- Reload collision: at free_count = 4, reload in the same cycle as ev_in -> free_count = 10 and no reject. An entry held across an rst_n pulse -> exactly one decrement after reset.

Source files
------------

// File: rtl/free_space_down_counter_pkg.sv
// Purpose: shared parameter defaults and capacity check for the parking-lot counter family.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Reused by the display and gate controller so every block agrees on WIDTH/CAPACITY.
package free_space_down_counter_pkg;

    localparam int FSDC_WIDTH_DEF    = 4;
    localparam int FSDC_CAPACITY_DEF = 10;

    // The count must be able to hold CAPACITY without wrapping.
    function automatic bit fsdc_capacity_fits(input int width, input int capacity);
        return (capacity >= 0) && (capacity < (1 << width));
    endfunction

endpackage

// File: rtl/free_space_down_counter_if.sv
// Purpose: groups the gate-sensor inputs and the counter/flag outputs of the free-space counter.
// Latency: n/a (wiring only).
// Backpressure: none; sensors are level inputs and outputs are free-running registers.
// Ports: enter_sensor/exit_sensor/reload into the counter; free_count, lot_full, lot_empty,
// reject and exit_error out of it. master = sensor/display side, slave = counter.
interface free_space_down_counter_if #(
    parameter int WIDTH = free_space_down_counter_pkg::FSDC_WIDTH_DEF
);
    logic             enter_sensor;
    logic             exit_sensor;
    logic             reload;
    logic [WIDTH-1:0] free_count;
    logic             lot_full;
    logic             lot_empty;
    logic             reject;
    logic             exit_error;

    modport master (
        output enter_sensor, exit_sensor, reload,
        input  free_count, lot_full, lot_empty, reject, exit_error
    );

    modport slave (
        input  enter_sensor, exit_sensor, reload,
        output free_count, lot_full, lot_empty, reject, exit_error
    );
endinterface

// File: rtl/free_space_down_counter_full_subtractor.sv
// Purpose: one-bit full subtractor cell (bit1 - bit2 - borrow_in) for the ripple-borrow chain.
// Latency: combinational.
// Backpressure: n/a.
// Ports: bit1 minuend, bit2 subtrahend, borrow_in from lower bit; result, borrow_out to upper bit.
module full_subtractor (
    input  logic bit1,
    input  logic bit2,
    input  logic borrow_in,
    output logic result,
    output logic borrow_out
);
    assign result     = bit1 ^ bit2 ^ borrow_in;
    assign borrow_out = (~bit1 & bit2) | (~(bit1 ^ bit2) & borrow_in);
endmodule

// File: rtl/free_space_down_counter.sv
// Purpose: free parking-space counter; entry decrements, exit increments via one ripple-borrow subtractor.
// Latency: sensor first sampled high at edge N updates free_count/flags at edge N+2.
// Backpressure: none; events at full/empty are held off and flagged with reject/exit_error pulses.
// Ports: clk, rst_n (async active-low); bus (slave) carries sensors, reload, count and flags.
module free_space_down_counter
    import free_space_down_counter_pkg::*;
#(
    parameter int WIDTH    = FSDC_WIDTH_DEF,
    parameter int CAPACITY = FSDC_CAPACITY_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    free_space_down_counter_if.slave        bus
);

    if (!fsdc_capacity_fits(WIDTH, CAPACITY)) begin : g_cap_check
        $error("CAPACITY must be < 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] CAP_W = WIDTH'(CAPACITY);

    // Two-flop synchronizer plus a history flop per sensor.
    logic enter_s1_q, enter_s2_q, enter_s3_q;
    logic exit_s1_q,  exit_s2_q,  exit_s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_s1_q <= 1'b0;
            enter_s2_q <= 1'b0;
            enter_s3_q <= 1'b0;
            exit_s1_q  <= 1'b0;
            exit_s2_q  <= 1'b0;
            exit_s3_q  <= 1'b0;
        end else begin
            enter_s1_q <= bus.enter_sensor;
            enter_s2_q <= enter_s1_q;
            enter_s3_q <= enter_s2_q;
            exit_s1_q  <= bus.exit_sensor;
            exit_s2_q  <= exit_s1_q;
            exit_s3_q  <= exit_s2_q;
        end
    end

    // Rising edge of the synchronized level: one pulse per car, re-armed when the level drops.
    logic ev_in, ev_out;
    assign ev_in  = enter_s2_q & ~enter_s3_q;
    assign ev_out = exit_s2_q  & ~exit_s3_q;

    logic [WIDTH-1:0] free_count_q, free_count_d;
    logic             lot_full_q, lot_empty_q;
    logic             reject_q, reject_d;
    logic             exit_error_q, exit_error_d;

    // Exit adds one by subtracting all-ones; entry subtracts one.
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   borrow_chain;
    logic             unused_final_borrow;

    assign operand         = (ev_out & ~ev_in) ? {WIDTH{1'b1}} : WIDTH'(1);
    assign borrow_chain[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sub
        full_subtractor u_fs (
            .bit1       (free_count_q[i]),
            .bit2       (operand[i]),
            .borrow_in  (borrow_chain[i]),
            .result     (diff[i]),
            .borrow_out (borrow_chain[i+1])
        );
    end

    // The guards below keep the count in 0..CAPACITY, so the top borrow is never meaningful.
    assign unused_final_borrow = borrow_chain[WIDTH];

    always_comb begin
        free_count_d = free_count_q;
        reject_d     = 1'b0;
        exit_error_d = 1'b0;
        if (bus.reload) begin
            free_count_d = CAP_W;
        end else if (ev_in && ev_out) begin
            free_count_d = free_count_q;      // car swap is net zero
        end else if (ev_in) begin
            if (free_count_q != '0) free_count_d = diff;
            else                    reject_d     = 1'b1;
        end else if (ev_out) begin
            if (free_count_q != CAP_W) free_count_d = diff;
            else                       exit_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_count_q <= CAP_W;
            lot_full_q   <= 1'b0;
            lot_empty_q  <= 1'b1;
            reject_q     <= 1'b0;
            exit_error_q <= 1'b0;
        end else begin
            free_count_q <= free_count_d;
            // Flags come from the next-state value so they move with free_count.
            lot_full_q   <= (free_count_d == '0);
            lot_empty_q  <= (free_count_d == CAP_W);
            reject_q     <= reject_d;
            exit_error_q <= exit_error_d;
        end
    end

    assign bus.free_count = free_count_q;
    assign bus.lot_full   = lot_full_q;
    assign bus.lot_empty  = lot_empty_q;
    assign bus.reject     = reject_q;
    assign bus.exit_error = exit_error_q;

endmodule
